// File: rtl/micro_sequencer.sv
// Microprogram sequencer: holds CAR, IR and PC and selects the next
// microinstruction address from the control-word fields and ALU flags.
module micro_sequencer #(
    parameter int unsigned     CAR_W     = 8,
    parameter int unsigned     PC_W      = 16,
    parameter int unsigned     IR_W      = 16,
    parameter logic [CAR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [CAR_W-1:0]  na,
    input  logic [2:0]        ms,
    input  logic              mc,
    input  logic              il,
    input  logic              pi,
    input  logic              pl,
    input  logic              flag_v,
    input  logic              flag_c,
    input  logic              flag_n,
    input  logic              flag_z,
    input  logic [IR_W-1:0]   instr_in,
    output logic [CAR_W-1:0]  car,
    output logic [IR_W-1:0]   ir,
    output logic [PC_W-1:0]   pc,
    output logic              br_taken
);

    localparam int unsigned OPC_W = 7;
    localparam int unsigned OFF_W = 6;

    typedef enum logic [2:0] {
        MS_CNT = 3'b000,
        MS_NXT = 3'b001,
        MS_BC  = 3'b010,
        MS_BV  = 3'b011,
        MS_BZ  = 3'b100,
        MS_BN  = 3'b101,
        MS_BNC = 3'b110,
        MS_BNZ = 3'b111
    } ms_e;

    logic              cond;
    logic [CAR_W-1:0]  map_addr;
    logic [CAR_W-1:0]  target;
    logic [OFF_W-1:0]  off6;
    logic [PC_W-1:0]   pc_off;
    logic [CAR_W-1:0]  car_nxt;
    logic [IR_W-1:0]   ir_nxt;
    logic [PC_W-1:0]   pc_nxt;

    // Branch condition select
    always_comb begin
        cond = 1'b0;
        case (ms_e'(ms))
            MS_CNT: cond = 1'b0;
            MS_NXT: cond = 1'b1;
            MS_BC:  cond = flag_c;
            MS_BV:  cond = flag_v;
            MS_BZ:  cond = flag_z;
            MS_BN:  cond = flag_n;
            MS_BNC: cond = ~flag_c;
            MS_BNZ: cond = ~flag_z;
            default: cond = 1'b0;
        endcase
    end

    assign br_taken = cond;
    assign map_addr = CAR_W'({1'b1, ir[IR_W-1 -: OPC_W]});
    assign target   = mc ? map_addr : na;

    // PC-relative offset comes from the registered IR, never from instr_in
    assign off6   = {ir[8:6], ir[2:0]};
    assign pc_off = {{(PC_W-OFF_W){off6[OFF_W-1]}}, off6};

    always_comb begin
        car_nxt = car;
        ir_nxt  = ir;
        pc_nxt  = pc;
        if (en) begin
            car_nxt = cond ? target : car + CAR_W'(1);
            if (il) begin
                ir_nxt = instr_in;
            end
            if (pl) begin
                pc_nxt = pc + pc_off;
            end else if (pi) begin
                pc_nxt = pc + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            car <= RESET_VEC;
            ir  <= '0;
            pc  <= '0;
        end else begin
            car <= car_nxt;
            ir  <= ir_nxt;
            pc  <= pc_nxt;
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: behavioural model checked every
// cycle plus literal expectations for the key sequencing scenarios.
module tb_micro_sequencer;

    logic        clk;
    logic        rstn;
    logic        en;
    logic [7:0]  na;
    logic [2:0]  ms;
    logic        mc;
    logic        il;
    logic        pi;
    logic        pl;
    logic        flag_v;
    logic        flag_c;
    logic        flag_n;
    logic        flag_z;
    logic [15:0] instr_in;
    logic [7:0]  car;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        br_taken;

    int n_total = 0;
    int n_pass  = 0;

    int m_car = 0;
    int m_ir  = 0;
    int m_pc  = 0;

    micro_sequencer #(
        .CAR_W(8), .PC_W(16), .IR_W(16), .RESET_VEC(8'h00)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .na(na), .ms(ms), .mc(mc),
        .il(il), .pi(pi), .pl(pl),
        .flag_v(flag_v), .flag_c(flag_c), .flag_n(flag_n), .flag_z(flag_z),
        .instr_in(instr_in), .car(car), .ir(ir), .pc(pc), .br_taken(br_taken)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Condition table indexed by ms: CNT NXT C V Z N ~C ~Z
    function automatic bit model_cond(input int sel, input bit v, input bit c,
                                      input bit n, input bit z);
        bit tab[8];
        tab[0] = 1'b0; tab[1] = 1'b1; tab[2] = c;  tab[3] = v;
        tab[4] = z;    tab[5] = n;    tab[6] = !c; tab[7] = !z;
        return tab[sel];
    endfunction

    // Compare and then advance the model; inputs are stable from posedge+1 to next posedge
    always @(negedge clk) begin
        int  e_car, e_ir, e_pc, off, tgt;
        bit  cnd;
        cnd = model_cond(int'(ms), flag_v, flag_c, flag_n, flag_z);
        if (!rstn) begin
            e_car = 0; e_ir = 0; e_pc = 0;
        end else begin
            e_car = m_car; e_ir = m_ir; e_pc = m_pc;
        end
        check("model_car", int'(car), e_car);
        check("model_ir",  int'(ir),  e_ir);
        check("model_pc",  int'(pc),  e_pc);
        check("model_br",  int'(br_taken), int'(cnd));
        if (!rstn) begin
            m_car = 0; m_ir = 0; m_pc = 0;
        end else if (en) begin
            tgt = mc ? (128 + ((m_ir / 512) % 128)) : int'(na);
            off = ((m_ir / 64) % 8) * 8 + (m_ir % 8);
            if (off >= 32) off -= 64;
            if (pl)      m_pc = (m_pc + off + 65536) % 65536;
            else if (pi) m_pc = (m_pc + 1) % 65536;
            if (il)      m_ir = int'(instr_in);
            m_car = cnd ? tgt : (m_car + 1) % 256;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b1; na = 8'h00; ms = 3'b000; mc = 1'b0;
        il = 1'b0; pi = 1'b0; pl = 1'b0;
        flag_v = 1'b0; flag_c = 1'b0; flag_n = 1'b0; flag_z = 1'b0;
        instr_in = 16'h0000;
    endtask

    task automatic jump(input logic [7:0] addr);
        idle();
        ms = 3'b001; na = addr;
        tick();
    endtask

    // Branch from car=8'h10 toward na=8'h20 with flags {v,c,n,z}
    task automatic br_case(input string name, input logic [2:0] sel,
                           input logic [3:0] f, input int exp);
        jump(8'h10);
        idle();
        ms = sel; na = 8'h20;
        {flag_v, flag_c, flag_n, flag_z} = f;
        tick();
        if (exp >= 0) check(name, int'(car), exp);
    endtask

    initial begin
        logic [3:0] fpat [4];
        fpat[0] = 4'b0000; fpat[1] = 4'b1111; fpat[2] = 4'b0101; fpat[3] = 4'b1010;

        idle();
        rstn = 1'b0;
        tick();
        tick();
        check("rst_car", int'(car), 8'h00);
        check("rst_ir",  int'(ir),  16'h0000);
        check("rst_pc",  int'(pc),  16'h0000);
        rstn = 1'b1;
        tick();
        check("first_cnt", int'(car), 8'h01);

        // Build car=42, pc=0100, then abort with reset mid-run
        idle();
        ms = 3'b001; na = 8'h42; pi = 1'b1;
        repeat (256) tick();
        check("pre_rst_car", int'(car), 8'h42);
        check("pre_rst_pc",  int'(pc),  16'h0100);
        rstn = 1'b0;
        #1;
        check("async_rst_car", int'(car), 8'h00);
        check("async_rst_pc",  int'(pc),  16'h0000);
        check("async_rst_ir",  int'(ir),  16'h0000);
        tick();
        idle();
        rstn = 1'b1;
        tick();
        check("post_rst_car", int'(car), 8'h01);

        // Wrap, CNT and NXT
        jump(8'hFF);
        check("jump_ff", int'(car), 8'hFF);
        idle();
        tick();
        check("wrap", int'(car), 8'h00);
        idle();
        ms = 3'b001; na = 8'h37;
        #1;
        check("nxt_br_taken", int'(br_taken), 1);
        tick();
        check("nxt_car", int'(car), 8'h37);

        // Conditional branches
        br_case("bz_taken",  3'b100, 4'b0001, 8'h20);
        br_case("bz_not",    3'b100, 4'b0000, 8'h11);
        br_case("bnz_taken", 3'b111, 4'b0000, 8'h20);
        br_case("bnc_not",   3'b110, 4'b0100, 8'h11);
        for (int s = 0; s < 8; s++)
            for (int k = 0; k < 4; k++)
                br_case("sweep", 3'(s), fpat[k], -1);

        // Opcode map
        idle();
        il = 1'b1; instr_in = 16'hA400;
        tick();
        check("ir_load", int'(ir), 16'hA400);
        idle();
        ms = 3'b001; mc = 1'b1;
        tick();
        check("map_car", int'(car), 8'hD2);

        // PC arithmetic; pc is 0 here
        idle();
        pi = 1'b1;
        repeat (16) tick();
        check("pc_10", int'(pc), 16'h0010);
        idle();
        il = 1'b1; instr_in = 16'h01C6;
        tick();
        idle();
        pl = 1'b1; pi = 1'b1;
        tick();
        check("pl_over_pi", int'(pc), 16'h000E);
        idle();
        pi = 1'b1;
        tick();
        check("pi_only", int'(pc), 16'h000F);
        idle();
        il = 1'b1; instr_in = 16'h01C7;
        tick();
        idle();
        pl = 1'b1;
        repeat (16) tick();
        check("pc_ffff", int'(pc), 16'hFFFF);
        idle();
        pi = 1'b1;
        tick();
        check("pc_wrap", int'(pc), 16'h0000);
        idle();
        il = 1'b1; pl = 1'b1; instr_in = 16'h01C6;
        tick();
        check("il_pl_pc", int'(pc), 16'hFFFF);
        check("il_pl_ir", int'(ir), 16'h01C6);

        // Stall
        jump(8'h55);
        idle();
        en = 1'b0; ms = 3'b001; na = 8'h77; il = 1'b1; pi = 1'b1;
        instr_in = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            {flag_v, flag_c, flag_n, flag_z} = 4'(i * 5);
            tick();
        end
        check("stall_car", int'(car), 8'h55);
        check("stall_ir",  int'(ir),  16'h01C6);
        check("stall_pc",  int'(pc),  16'hFFFF);
        en = 1'b1;
        tick();
        check("resume_car", int'(car), 8'h77);
        check("resume_ir",  int'(ir),  16'h1234);
        check("resume_pc",  int'(pc),  16'h0000);

        idle();
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
